// File: rtl/ppu_result_checker.sv
// ppu_result_checker
//   Receiving end of a posit result stream. Accepts {result, expected}
//   beats over valid/ready, forms the absolute bit-pattern difference of
//   each pair (with NaR special-casing), and accumulates error statistics
//   over a programmed run length.
//
//   Optional feature, enabled by defining PPU_CHK_HIST_EN:
//     adds hist0..hist3, saturating counts of diff == 0, diff == 1,
//     2 <= diff <= 3 and diff >= 4 over the current run.
module ppu_result_checker #(
  parameter int          N     = 32,
  parameter int          es    = 2,
  parameter int          LEN_W = 16,
  parameter int unsigned TOL   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [N-1:0]     res_data,
  input  logic [N-1:0]     exp_data,
  output logic [N-1:0]     diff,
  output logic             diff_valid,
  output logic [LEN_W-1:0] err_count,
  output logic [N-1:0]     max_diff,
  output logic [LEN_W-1:0] first_err_idx,
  output logic             first_err_vld,
  output logic             busy,
  output logic             done
`ifdef PPU_CHK_HIST_EN
  ,
  output logic [LEN_W-1:0] hist0,
  output logic [LEN_W-1:0] hist1,
  output logic [LEN_W-1:0] hist2,
  output logic [LEN_W-1:0] hist3
`endif
);

  // The exponent size plays no part in a raw bit-pattern comparison; it is
  // only range-checked so a nonsensical configuration fails at elaboration.
  if (es < 0 || es > N - 2) begin : g_bad_es
    $error("ppu_result_checker: es out of range for N");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [N-1:0] NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] TOL_V = N'(TOL);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             last_beat;
  logic             start_ok;
  logic             res_nar;
  logic             exp_nar;
  logic [N-1:0]     diff_c;
  logic             is_err;

  assign accept    = res_valid && res_ready;
  assign last_beat = (beat_cnt == len_q - 1'b1);
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

  // Absolute difference of the raw patterns; NaR compares equal only to NaR
  // and is maximally distant from every real value.
  always_comb begin
    res_nar = (res_data == NAR);
    exp_nar = (exp_data == NAR);
    if (res_nar && exp_nar) begin
      diff_c = '0;
    end else if (res_nar ^ exp_nar) begin
      diff_c = '1;
    end else if (res_data > exp_data) begin
      diff_c = res_data - exp_data;
    end else begin
      diff_c = exp_data - res_data;
    end
  end

  assign is_err = (diff_c > TOL_V);

  // State register.
  // NOTE: the reset is asynchronous so an aborted run drops its outputs
  // immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    res_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (run_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        res_ready = 1'b1;
        busy      = 1'b1;
        if (accept && last_beat) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = (run_len == '0) ? S_DONE : S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Beat counter and latched run length.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      len_q    <= '0;
    end else if (start_ok) begin
      beat_cnt <= '0;
      len_q    <= run_len;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Registered diff: lands one cycle after its beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      diff_valid <= 1'b0;
    end else begin
      diff_valid <= accept;
      if (accept) diff <= diff_c;
    end
  end

  // Run statistics, updated on the same edge as diff so they are current
  // in the diff_valid cycle and frozen once the run ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count     <= '0;
      max_diff      <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (start_ok) begin
      err_count     <= '0;
      max_diff      <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (accept) begin
      if (is_err && (err_count != '1)) err_count <= err_count + 1'b1;
      if (diff_c > max_diff) max_diff <= diff_c;
      if (is_err && !first_err_vld) begin
        first_err_idx <= beat_cnt;
        first_err_vld <= 1'b1;
      end
    end
  end

`ifdef PPU_CHK_HIST_EN
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Diff-magnitude histogram, binned on the same edge as the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
      hist3 <= '0;
    end else if (start_ok) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
      hist3 <= '0;
    end else if (accept) begin
      if (diff_c == N'(0))      hist0 <= sat_inc(hist0);
      else if (diff_c == N'(1)) hist1 <= sat_inc(hist1);
      else if (diff_c <= N'(3)) hist2 <= sat_inc(hist2);
      else                      hist3 <= sat_inc(hist3);
    end
  end
`endif

endmodule

// File: doc/ppu_result_checker.md
Name: ppu_result_checker

Overview:
- Hardware receiver and scoreboard for Posit Processing Unit result streams; the consuming end of the operand/result flow that drives the ppu.
- Accepts {result, expected} beats over a valid/ready handshake and computes the absolute bit-pattern difference of each pair.
- Accumulates error statistics over a programmed run length.
- Lets self-checking regressions run in emulation or post-synthesis simulation without file I/O.

Parameters:
- N, 32, posit word width
- es, 2, posit exponent size; carried for interface symmetry, no effect on the comparison
- LEN_W, 16, width of run-length and index counters
- TOL, 0, largest |diff| still counted as a pass

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches run_len and begins a run
- run_len  in  LEN_W  number of beats in the run
- res_valid  in  1  result beat valid
- res_ready  out  1  checker can accept a beat
- res_data  in  N  posit result from the ppu
- exp_data  in  N  golden posit value
- diff  out  N  |res_data − exp_data| of the last accepted beat (unsigned, raw bits)
- diff_valid  out  1  diff updated this cycle
- err_count  out  LEN_W  beats with diff > TOL
- max_diff  out  N  largest diff seen in the run
- first_err_idx  out  LEN_W  beat index (0-based) of the first error
- first_err_vld  out  1  first_err_idx is meaningful
- busy  out  1  run in progress
- done  out  1  run completed; held until the next start

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including res_ready, diff_valid, busy, done, err_count, max_diff, first_err_idx and first_err_vld.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: load beat counter = 0 and remaining = run_len.
  - Clear err_count, max_diff, first_err_*, done and histogram counters.
  - Go to RUN. If run_len = 0, go directly to DONE with done = 1 on the next cycle.
- RUN:
  - res_ready = 1.
  - Beat accepted when res_valid && res_ready.
  - On acceptance, the beat counter increments.
  - The last beat (counter = run_len−1) moves the FSM to DRAIN.
- Diff and NaR rule:
  - diff = (res > exp) ? res−exp : exp−res, computed as an unsigned N-bit value.
  - NaR is the pattern 1 followed by zeros.
  - If exactly one of res or exp is NaR, diff = all ones.
  - If both are NaR, diff = 0.
- Diff pipeline:
  - diff is registered.
  - diff_valid pulses exactly 1 cycle after each accepted beat; latency 1.
  - Statistics update in that same cycle.
- Statistics:
  - Error when diff > TOL.
  - err_count saturates at all ones.
  - max_diff = max(max_diff, diff).
  - first_err_idx/first_err_vld are set on the first error only.
- DRAIN: lasts one cycle for the final diff to land; then DONE.
- DONE: done = 1, busy = 0. Statistics are held stable until the next start.
- busy = 1 in RUN and DRAIN only.
- res_ready = 0 outside RUN, including the DRAIN cycle.
- start while busy is ignored.
- start in the same cycle as the last beat is ignored.
- Beats presented with res_valid while not in RUN are not accepted; the sender holds them.
- rst_n asserted mid-run aborts the run immediately to the reset state. No partial done is produced.

Optional Feature:
- Macro: PPU_CHK_HIST_EN.
- Defined: adds ports hist0, hist1, hist2, hist3 (each LEN_W, out), saturating counters of diff == 0, diff == 1, 2 ≤ diff ≤ 3 and diff ≥ 4.
  - Counters update with diff_valid and clear on start or reset.
- Undefined: no histogram ports or logic; all other behaviour is identical.

Test Plan:
- Reset mid-run: run_len = 8, assert rst_n = 0 after beat 3.
  - Expect all outputs 0 asynchronously, then state IDLE.
  - A following run_len = 2 run completes normally.
- Clean run: run_len = 4, res == exp on every beat (0x40000000, 0x3F000000, 0x00000000, 0x7FFFFFFF), res_valid held high.
  - Expect diff_valid on 4 consecutive cycles, each lagging acceptance by 1 cycle.
  - err_count = 0, max_diff = 0, first_err_vld = 0.
  - done = 1 two cycles after the last acceptance.
- Mismatch run: run_len = 3; beats (0x40000001 vs 0x40000000), (0x3FFFFFF0 vs 0x40000000), (equal).
  - Expect diff = 1, 0x10, 0.
  - err_count = 2, max_diff = 0x10, first_err_idx = 0.
- NaR handling, one beat each:
  - res = 0x80000000, exp = 0x40000000: expect diff = 0xFFFFFFFF, error counted.
  - Both 0x80000000: expect diff = 0, no error.
- Backpressure and zero length:
  - res_valid toggling 1/0 on alternate cycles: beats are accepted only when valid.
  - start during busy is ignored.
  - run_len = 0 gives done next cycle with res_ready never asserted.
- With PPU_CHK_HIST_EN, using diffs {0, 1, 3, 4, 100}: expect hist0..hist3 = 1, 1, 1, 2; with TOL = 1, err_count = 3.
